// File: rtl/isqrt_result_buffer.sv
// Result FIFO with credit return for the no-backpressure 8-stage isqrt pipe.
// Captures every result strobe and re-presents results on a show-ahead valid/ready stream.
module isqrt_result_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         res_data,
  output logic                     issue_ok,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] CREDIT_MAX = (AW+2)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [AW:0]      infl_q, infl_d;
  logic             err_q, err_d;

  logic             full;
  logic             pop;
  logic             push_acc;
  logic             drop;
  logic             underflow;
  logic             overrun;
  logic [AW+1:0]    credit_sum;

  // Credit and stream outputs come from registers only, so no input reaches issue_ok.
  assign credit_sum = {1'b0, infl_q} + {1'b0, occ_q};
  assign issue_ok   = credit_sum < CREDIT_MAX;
  assign out_valid  = (occ_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign occupancy  = occ_q;
  assign inflight   = infl_q;
  assign err        = err_q;

  assign full      = (occ_q == FULL_CNT);
  assign pop       = out_valid & out_ready;
  assign push_acc  = res_valid & (~full | pop);
  assign drop      = res_valid & full & ~pop;
  assign underflow = res_valid & ~run & (infl_q == '0);
  assign overrun   = run & ~issue_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    infl_d   = infl_q;
    err_d    = err_q | drop | underflow | overrun;

    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
    occ_d = occ_q + (AW+1)'(push_acc) - (AW+1)'(pop);

    // A result with nothing outstanding is flagged and the counter is held at zero.
    if (run && !res_valid) begin
      infl_d = infl_q + (AW+1)'(1);
    end else if (res_valid && !run && (infl_q != '0)) begin
      infl_d = infl_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  // Storage carries no reset; out_valid masks stale entries.
  always_ff @(posedge clock) begin
    if (push_acc && !reset) mem_q[wr_ptr_q] <= res_data;
  end

endmodule

// File: tb/tb_isqrt_result_buffer.sv
// Bench for isqrt_result_buffer: models the 8-cycle isqrt pipe and the buffer with queues,
// checks every cycle, plus directed scenarios and a randomized stream.
module tb_isqrt_result_buffer;
  localparam int DEPTH = 16;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int LAT   = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             run;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             issue_ok;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    occupancy;
  logic [CW-1:0]    inflight;
  logic             err;
  logic [31:0]      x_in;

  always #5 clock = ~clock;

  isqrt_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .run(run), .res_valid(res_valid), .res_data(res_data),
    .issue_ok(issue_ok), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .inflight(inflight), .err(err)
  );

  // Reference state
  int               n_cmp = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int               m_infl = 0;
  bit               m_err = 1'b0;
  bit               chk_en = 1'b0;
  bit               inj = 1'b0;
  bit               pv[LAT];
  logic [WIDTH-1:0] pd[LAT];

  function automatic logic [WIDTH-1:0] isqrt(input logic [31:0] x);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] t;
    r = '0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      t = r | (WIDTH'(1) << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  function automatic bit m_issue_ok();
    return (m_infl + m_q.size()) < DEPTH;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the queue model
  always @(negedge clock) begin
    if (chk_en) begin
      check("out_valid", out_valid, m_q.size() != 0);
      check("occupancy", occupancy, m_q.size());
      check("inflight", inflight, m_infl);
      check("issue_ok", issue_ok, m_issue_ok());
      check("err", err, m_err);
      if (m_q.size() != 0) begin
        check("out_data", out_data, m_q[0]);
        check("order_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("order", out_data, exp_q[0]);
      end
    end
  end

  task automatic model_update();
    bit pop;
    bit full;
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_infl = 0;
      m_err  = 1'b0;
      return;
    end
    if (run && (m_infl + m_q.size() >= DEPTH)) m_err = 1'b1;
    if (run && !res_valid) m_infl++;
    else if (res_valid && !run) begin
      if (m_infl == 0) m_err = 1'b1;
      else m_infl--;
    end
    pop  = (m_q.size() != 0) && out_ready;
    full = (m_q.size() == DEPTH);
    if (pop) begin
      void'(m_q.pop_front());
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (run) exp_q.push_back(isqrt(x_in));
    if (res_valid) begin
      if (!full || pop) begin
        m_q.push_back(res_data);
        if (inj) exp_q.insert(exp_q.size() - (run ? 1 : 0), res_data);
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  // One clock: update model at the edge, advance the pipe model, present its output
  task automatic tick();
    @(posedge clock);
    model_update();
    if (reset) begin
      for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = run;
      pd[0] = isqrt(x_in);
    end
    #1;
    inj       = 1'b0;
    res_valid = pv[LAT-1];
    res_data  = pv[LAT-1] ? pd[LAT-1] : '0;
  endtask

  task automatic inject(input logic [WIDTH-1:0] v);
    inj       = 1'b1;
    res_valid = 1'b1;
    res_data  = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int issued;
    int cyc;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    reset = 1'b1; run = 1'b0; out_ready = 1'b0; res_valid = 1'b0; res_data = '0; x_in = '0;

    check("isqrt_144", isqrt(32'd144), 12);
    check("isqrt_99", isqrt(32'd99), 9);
    check("isqrt_max", isqrt(32'hFFFF_FFFF), 65535);

    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_occupancy", occupancy, 0);
    check("rst_issue_ok", issue_ok, 1);
    check("rst_out_valid", out_valid, 0);

    // Single result: x=144 -> 12, visible 9 cycles after run
    run = 1'b1; x_in = 32'd144;
    tick();
    run = 1'b0;
    repeat (7) tick();
    @(negedge clock);
    check("t1_not_yet_valid", out_valid, 0);
    tick();
    @(negedge clock);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 12);
    check("t1_inflight", inflight, 0);
    check("t1_err", err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill with downstream stalled: credit allows exactly DEPTH runs
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      run  = m_issue_ok();
      x_in = $urandom;
      if (run) acc++;
      tick();
    end
    run = 1'b0;
    repeat (10) tick();
    @(negedge clock);
    check("t2_accepted", acc, DEPTH);
    check("t2_occupancy", occupancy, DEPTH);
    check("t2_issue_ok", issue_ok, 0);
    check("t2_err", err, 0);

    // Full FIFO with simultaneous pop and push: nothing dropped
    out_ready = 1'b1;
    inject(16'hBEEF);
    tick();
    out_ready = 1'b0;
    @(negedge clock);
    check("t3_occupancy", occupancy, DEPTH);
    // Push into full FIFO without pop: dropped
    inject(16'hDEAD);
    tick();
    @(negedge clock);
    check("t3_drop_occupancy", occupancy, DEPTH);
    check("t3_drop_err", err, 1);
    out_ready = 1'b1;
    repeat (20) tick();
    out_ready = 1'b0;
    @(negedge clock);
    check("t3_drained", occupancy, 0);

    // Underflow and credit overrun
    do_reset();
    inject(16'h0077);
    tick();
    @(negedge clock);
    check("t4_underflow_err", err, 1);
    check("t4_underflow_inflight", inflight, 0);
    check("t4_underflow_pushed", occupancy, 1);
    repeat (3) tick();
    @(negedge clock);
    check("t4_sticky_err", err, 1);
    do_reset();
    for (int c = 0; c < DEPTH; c++) begin
      run = 1'b1; x_in = $urandom;
      tick();
    end
    @(negedge clock);
    check("t4_credit_exhausted", issue_ok, 0);
    check("t4_err_clean", err, 0);
    tick();
    run = 1'b0;
    @(negedge clock);
    check("t4_overrun_err", err, 1);

    // Reset with 5 in flight and 3 stored
    do_reset();
    for (int c = 0; c < 8; c++) begin
      run = 1'b1; x_in = $urandom;
      tick();
    end
    run = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check("t5_pre_occupancy", occupancy, 3);
    check("t5_pre_inflight", inflight, 5);
    do_reset();
    @(negedge clock);
    check("t5_occupancy", occupancy, 0);
    check("t5_inflight", inflight, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_issue_ok", issue_ok, 1);
    check("t5_err", err, 0);

    // Randomized stream, random stalls, run gated by credit
    issued = 0;
    cyc    = 0;
    while (issued < 1000 && cyc < 20000) begin
      run       = m_issue_ok() && ($urandom_range(0, 3) != 0);
      x_in      = $urandom;
      out_ready = $urandom_range(0, 1);
      if (run) issued++;
      cyc++;
      tick();
    end
    run = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    @(negedge clock);
    check("t6_issued", issued, 1000);
    check("t6_drained", occupancy, 0);
    check("t6_err", err, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
